// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// default widths and the address range check.
package ram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Addresses at or above the populated depth never reach the RAM.
    function automatic logic out_of_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port RAM with a shared tri-state
// data bus; one access every three cycles (IDLE -> ACCESS -> RESP).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                state_reg;
    logic                  last_grant_reg;
    logic                  grant_idx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  ack0_reg;
    logic                  ack1_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic                  ram_cs_reg;
    logic                  ram_we_reg;
    logic                  ram_oe_reg;

    logic                  grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_oor;

    rr_arbiter2 u_rr (
        .req        ({req1, req0}),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign sel_we    = grant ? we1    : we0;
    assign sel_addr  = grant ? addr1  : addr0;
    assign sel_wdata = grant ? wdata1 : wdata0;
    assign sel_oor   = out_of_range(32'(sel_addr), 32'(DEPTH));

    // Only the write phase of an access drives the bus; otherwise the RAM owns it.
    assign ram_data = (ram_cs_reg && ram_we_reg) ? wdata_reg : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_idx_reg  <= 1'b0;
            wdata_reg      <= '0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
            ram_addr_reg   <= '0;
            ram_cs_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_oe_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_idx_reg  <= grant;
                        last_grant_reg <= grant;
                        wdata_reg      <= sel_wdata;
                        if (sel_oor) begin
                            // Skip the RAM entirely and answer with an error next cycle.
                            ack0_reg  <= ~grant;
                            ack1_reg  <= grant;
                            err_reg   <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            ram_cs_reg   <= 1'b1;
                            ram_addr_reg <= sel_addr;
                            ram_we_reg   <= sel_we;
                            ram_oe_reg   <= ~sel_we;
                            state_reg    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The RAM put read data on the bus at the falling edge mid-cycle.
                    if (!ram_we_reg) begin
                        rdata_reg <= ram_data;
                    end
                    ram_cs_reg <= 1'b0;
                    ram_we_reg <= 1'b0;
                    ram_oe_reg <= 1'b0;
                    ack0_reg   <= ~grant_idx_reg;
                    ack1_reg   <= grant_idx_reg;
                    err_reg    <= 1'b0;
                    state_reg  <= RESP;
                end
                RESP: begin
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack0     = ack0_reg;
    assign ack1     = ack1_reg;
    assign err      = err_reg;
    assign rdata    = rdata_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_cs   = ram_cs_reg;
    assign ram_we   = ram_we_reg;
    assign ram_oe   = ram_oe_reg;

endmodule
